// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
//    Shared constants and types for the pong blocks (paddle, ball, VGA).
//    Contents:
//       SCREEN_W / SCREEN_H         visible area in pixels
//       PADDLE_W / PADDLE_Y         paddle width and top row
//       PADDLE_X_MIN / PADDLE_X_MAX travel limits of the paddle left edge
//       game_state_t                IDLE / PLAY / GAME_OVER
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int PADDLE_W     = 80;
   localparam int PADDLE_Y     = 450;
   localparam int PADDLE_X_MIN = 5;
   localparam int PADDLE_X_MAX = 555;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAY      = 2'd1,
      GAME_OVER = 2'd2
   } game_state_t;

endpackage

// File: rtl/button_edge.sv
// ---------------------------------------------------------------------------
// button_edge
//    Registers a level button once per clock and flags its rising edge.
//    Holding the button produces a single pulse.
//    Ports:
//       clk   in   clock
//       rst   in   asynchronous active-high reset (clears the history)
//       btn   in   button level
//       rise  out  high for the tick where btn is 1 and was 0 last tick
// ---------------------------------------------------------------------------
module button_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic btn_q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q_reg <= 1'b0;
      end else begin
         btn_q_reg <= btn;
      end
   end

   assign rise = btn & ~btn_q_reg;

endmodule

// File: rtl/ball_movement.sv
// ---------------------------------------------------------------------------
// ball_movement
//    Owns the ball: moves it one pixel per axis per tick, bounces it off the
//    left/right/top walls and the paddle, detects a miss at the bottom, and
//    runs the serve / lives / game-over sequence.
//    Ports:
//       Ball_Clock   in   movement tick
//       reset        in   asynchronous active-high reset
//       serve        in   serve button level (acted on at its rising edge)
//       paddle_x     in   paddle left edge
//       ball_x       out  ball left edge
//       ball_y       out  ball top edge
//       ball_active  out  high while in PLAY
//       hit          out  one-tick pulse on a paddle bounce
//       miss         out  one-tick pulse when the ball reaches the bottom
//       lives_left   out  remaining lives
//       game_over    out  high while in GAME_OVER
// ---------------------------------------------------------------------------
module ball_movement
   import pong_pkg::*;
#(
   parameter int BALL_SIZE = 10,
   parameter int START_X   = 315,
   parameter int START_Y   = 100,
   parameter int LIVES     = 3
) (
   input  logic       Ball_Clock,
   input  logic       reset,
   input  logic       serve,
   input  logic [9:0] paddle_x,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       ball_active,
   output logic       hit,
   output logic       miss,
   output logic [1:0] lives_left,
   output logic       game_over
);

   localparam logic [9:0] X_MAX   = 10'(SCREEN_W - BALL_SIZE);
   localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0] X_START = 10'(START_X);
   localparam logic [9:0] Y_START = 10'(START_Y);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   game_state_t state_reg, state_next;
   logic [9:0]  ball_x_reg, ball_x_next;
   logic [9:0]  ball_y_reg, ball_y_next;
   // Direction flags: 1 means moving towards smaller coordinates.
   logic        dx_neg_reg, dx_neg_next;
   logic        dy_neg_reg, dy_neg_next;
   logic        serve_dir_reg, serve_dir_next;
   logic        hit_reg, hit_next;
   logic        miss_reg, miss_next;
   logic [1:0]  lives_reg, lives_next;
   logic        game_over_reg, game_over_next;

   logic        serve_rise;

   button_edge u_serve_edge (
      .clk  (Ball_Clock),
      .rst  (reset),
      .btn  (serve),
      .rise (serve_rise)
   );

   // Edge sums are 11 bits wide so paddle_x near 1023 cannot wrap the overlap test.
   logic [10:0] ball_right;
   logic [10:0] ball_bottom;
   logic [10:0] paddle_right;
   logic        paddle_overlap;
   logic        at_left, at_right, at_top, at_bottom, on_paddle;

   always_comb begin
      ball_right     = {1'b0, ball_x_reg} + 11'(BALL_SIZE);
      ball_bottom    = {1'b0, ball_y_reg} + 11'(BALL_SIZE);
      paddle_right   = {1'b0, paddle_x} + 11'(PADDLE_W);
      paddle_overlap = (ball_right > {1'b0, paddle_x}) && ({1'b0, ball_x_reg} < paddle_right);
      at_left        =  dx_neg_reg && (ball_x_reg == 10'd0);
      at_right       = !dx_neg_reg && (ball_x_reg == X_MAX);
      at_top         =  dy_neg_reg && (ball_y_reg == 10'd0);
      at_bottom      = !dy_neg_reg && (ball_y_reg == Y_MAX);
      on_paddle      = !dy_neg_reg && (ball_bottom == 11'(PADDLE_Y)) && paddle_overlap;
   end

   always_ff @(posedge Ball_Clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         ball_x_reg    <= X_START;
         ball_y_reg    <= Y_START;
         dx_neg_reg    <= 1'b0;
         dy_neg_reg    <= 1'b0;
         serve_dir_reg <= 1'b0;
         hit_reg       <= 1'b0;
         miss_reg      <= 1'b0;
         lives_reg     <= LIVES_INIT;
         game_over_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ball_x_reg    <= ball_x_next;
         ball_y_reg    <= ball_y_next;
         dx_neg_reg    <= dx_neg_next;
         dy_neg_reg    <= dy_neg_next;
         serve_dir_reg <= serve_dir_next;
         hit_reg       <= hit_next;
         miss_reg      <= miss_next;
         lives_reg     <= lives_next;
         game_over_reg <= game_over_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      ball_x_next    = ball_x_reg;
      ball_y_next    = ball_y_reg;
      dx_neg_next    = dx_neg_reg;
      dy_neg_next    = dy_neg_reg;
      serve_dir_next = serve_dir_reg;
      hit_next       = 1'b0;
      miss_next      = 1'b0;
      lives_next     = lives_reg;
      game_over_next = game_over_reg;

      unique case (state_reg)
         IDLE: begin
            ball_x_next = X_START;
            ball_y_next = Y_START;
            if (serve_rise) begin
               // Successive serves alternate the horizontal direction.
               dx_neg_next    = serve_dir_reg;
               dy_neg_next    = 1'b0;
               serve_dir_next = ~serve_dir_reg;
               state_next     = PLAY;
            end
         end

         PLAY: begin
            if (at_bottom) begin
               // Direction is kept; the ball just reloads at the start point.
               miss_next   = 1'b1;
               lives_next  = lives_reg - 2'd1;
               ball_x_next = X_START;
               ball_y_next = Y_START;
               if (lives_reg == 2'd1) begin
                  state_next     = GAME_OVER;
                  game_over_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               if (at_left) begin
                  dx_neg_next = 1'b0;
               end else if (at_right) begin
                  dx_neg_next = 1'b1;
               end
               if (at_top) begin
                  dy_neg_next = 1'b0;
               end else if (on_paddle) begin
                  dy_neg_next = 1'b1;
                  hit_next    = 1'b1;
               end
               // Move with the freshly bounced direction in the same tick.
               ball_x_next = dx_neg_next ? (ball_x_reg - 10'd1) : (ball_x_reg + 10'd1);
               ball_y_next = dy_neg_next ? (ball_y_reg - 10'd1) : (ball_y_reg + 10'd1);
            end
         end

         GAME_OVER: begin
            ball_x_next = X_START;
            ball_y_next = Y_START;
            if (serve_rise) begin
               lives_next     = LIVES_INIT;
               game_over_next = 1'b0;
               state_next     = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ball_x      = ball_x_reg;
   assign ball_y      = ball_y_reg;
   assign ball_active = (state_reg == PLAY);
   assign hit         = hit_reg;
   assign miss        = miss_reg;
   assign lives_left  = lives_reg;
   assign game_over   = game_over_reg;

endmodule

// File: tb/tb_ball_movement.sv
// ---------------------------------------------------------------------------
// tb_ball_movement
//    Self-checking bench for ball_movement: a table of scripted phases with
//    hand-derived expectations, hand-written sequences for game over, held
//    serve and asynchronous reset, and a long randomized run. Every tick is
//    also compared against an integer reference model of the game rules.
// ---------------------------------------------------------------------------
module tb_ball_movement;

   localparam int W      = 640;
   localparam int H      = 480;
   localparam int B      = 10;
   localparam int PW     = 80;
   localparam int PY     = 450;
   localparam int SX     = 315;
   localparam int SY     = 100;
   localparam int NLIVES = 3;

   localparam int MS_IDLE = 0;
   localparam int MS_PLAY = 1;
   localparam int MS_OVER = 2;

   logic       Ball_Clock = 1'b0;
   logic       reset      = 1'b1;
   logic       serve      = 1'b0;
   logic [9:0] paddle_x   = 10'd0;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       ball_active;
   logic       hit;
   logic       miss;
   logic [1:0] lives_left;
   logic       game_over;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Ball_Clock = ~Ball_Clock;

   ball_movement dut (
      .Ball_Clock  (Ball_Clock),
      .reset       (reset),
      .serve       (serve),
      .paddle_x    (paddle_x),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .ball_active (ball_active),
      .hit         (hit),
      .miss        (miss),
      .lives_left  (lives_left),
      .game_over   (game_over)
   );

   // ---------------- reference model (plain integer game rules) -------------
   int m_x, m_y, m_dx, m_dy, m_mode, m_lives;
   bit m_hit, m_miss, m_go, m_prev_serve, m_next_left;

   task automatic model_reset();
      m_x = SX; m_y = SY; m_dx = 1; m_dy = 1; m_mode = MS_IDLE;
      m_lives = NLIVES; m_hit = 0; m_miss = 0; m_go = 0;
      m_prev_serve = 0; m_next_left = 0;
   endtask

   task automatic model_step(input bit s, input int px);
      bit rise;
      int ndx, ndy;
      rise = s && !m_prev_serve;
      m_prev_serve = s;
      m_hit = 0;
      m_miss = 0;
      if (m_mode == MS_IDLE) begin
         if (rise) begin
            m_dx = m_next_left ? -1 : 1;
            m_dy = 1;
            m_next_left = !m_next_left;
            m_mode = MS_PLAY;
         end
      end else if (m_mode == MS_PLAY) begin
         if (m_dy == 1 && m_y == H - B) begin
            m_miss = 1;
            m_lives = m_lives - 1;
            m_x = SX;
            m_y = SY;
            if (m_lives == 0) begin
               m_mode = MS_OVER;
               m_go = 1;
            end else begin
               m_mode = MS_IDLE;
            end
         end else begin
            ndx = m_dx;
            ndy = m_dy;
            if (m_x == 0 && m_dx == -1) ndx = 1;
            if (m_x == W - B && m_dx == 1) ndx = -1;
            if (m_y == 0 && m_dy == -1) ndy = 1;
            if (m_dy == 1 && m_y + B == PY && m_x + B > px && m_x < px + PW) begin
               ndy = -1;
               m_hit = 1;
            end
            m_dx = ndx;
            m_dy = ndy;
            m_x = m_x + m_dx;
            m_y = m_y + m_dy;
         end
      end else begin
         if (rise) begin
            m_lives = NLIVES;
            m_go = 0;
            m_mode = MS_IDLE;
         end
      end
   endtask

   task automatic check_model(input string tag);
      bit exp_act;
      exp_act = (m_mode == MS_PLAY);
      n_cmp++;
      if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || ball_active !== exp_act ||
          hit !== m_hit || miss !== m_miss || lives_left !== 2'(m_lives) || game_over !== m_go) begin
         n_bad++;
         $display("FAIL %s @%0t: got x=%0d y=%0d act=%0b hit=%0b miss=%0b lives=%0d go=%0b; need x=%0d y=%0d act=%0b hit=%0b miss=%0b lives=%0d go=%0b",
                  tag, $time, ball_x, ball_y, ball_active, hit, miss, lives_left, game_over,
                  m_x, m_y, exp_act, m_hit, m_miss, m_lives, m_go);
      end
   endtask

   task automatic check_val(input string tag, input int got, input int need);
      n_cmp++;
      if (got != need) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d, need %0d", tag, $time, got, need);
      end
   endtask

   // One tick: drive inputs, step the model with the same inputs, compare.
   task automatic tick(input bit s, input int px, input string tag);
      serve = s;
      paddle_x = 10'(px);
      @(posedge Ball_Clock);
      model_step(s, px);
      #1;
      check_model(tag);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      serve = 1'b0;
      @(posedge Ball_Clock);
      @(posedge Ball_Clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Paddle placed where the ball cannot meet it, so a served ball will miss.
   function automatic int avoid_px();
      return (m_x < 320) ? 555 : 5;
   endfunction

   // ---------------- scripted phases ----------------
   typedef struct {
      bit rst;
      bit srv;
      int px;
      int n;
      int ex;
      int ey;
      bit eact;
      bit ehit;
      bit emiss;
      int elives;
      bit ego;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl[NV];

   initial begin
      int act_rises;
      bit prev_act;
      bit done;
      int budget;
      int px;

      // rst srv  px    n   x    y   act hit miss lives go
      tbl[0]  = '{1, 0, 555,   2, 315, 100, 0, 0, 0, 3, 0};
      tbl[1]  = '{0, 1, 555,   1, 315, 100, 1, 0, 0, 3, 0};
      tbl[2]  = '{0, 0, 555, 315, 630, 415, 1, 0, 0, 3, 0};
      tbl[3]  = '{0, 0, 555,  25, 605, 440, 1, 0, 0, 3, 0};
      tbl[4]  = '{0, 0, 555,   1, 604, 439, 1, 1, 0, 3, 0};
      tbl[5]  = '{0, 0, 555,   1, 603, 438, 1, 0, 0, 3, 0};
      tbl[6]  = '{1, 0,   5,   1, 315, 100, 0, 0, 0, 3, 0};
      tbl[7]  = '{0, 1,   5,   1, 315, 100, 1, 0, 0, 3, 0};
      tbl[8]  = '{0, 0,   5, 370, 575, 470, 1, 0, 0, 3, 0};
      tbl[9]  = '{0, 0,   5,   1, 315, 100, 0, 0, 1, 2, 0};
      tbl[10] = '{0, 0,   5,   1, 315, 100, 0, 0, 0, 2, 0};

      model_reset();
      apply_reset();
      check_val("reset_x", ball_x, SX);
      check_val("reset_y", ball_y, SY);
      check_val("reset_lives", lives_left, NLIVES);
      check_val("reset_act", ball_active, 0);

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].rst) apply_reset();
         for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].srv, tbl[i].px, "table_tick");
         n_cmp++;
         if (ball_x !== 10'(tbl[i].ex) || ball_y !== 10'(tbl[i].ey) || ball_active !== tbl[i].eact ||
             hit !== tbl[i].ehit || miss !== tbl[i].emiss || lives_left !== 2'(tbl[i].elives) ||
             game_over !== tbl[i].ego) begin
            n_bad++;
            $display("FAIL vec%0d: got x=%0d y=%0d act=%0b hit=%0b miss=%0b lives=%0d go=%0b; need x=%0d y=%0d act=%0b hit=%0b miss=%0b lives=%0d go=%0b",
                     i, ball_x, ball_y, ball_active, hit, miss, lives_left, game_over,
                     tbl[i].ex, tbl[i].ey, tbl[i].eact, tbl[i].ehit, tbl[i].emiss, tbl[i].elives, tbl[i].ego);
         end else begin
            $display("vec%0d: x=%0d y=%0d act=%0b hit=%0b miss=%0b lives=%0d go=%0b",
                     i, ball_x, ball_y, ball_active, hit, miss, lives_left, game_over);
         end
      end

      // ---------------- game over: three serve/miss cycles ----------------
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         tick(1, avoid_px(), "go_serve");
         done = 0;
         budget = 0;
         while (!done && budget < 2000) begin
            tick(0, avoid_px(), "go_play");
            done = m_miss;
            budget++;
         end
         check_val("go_miss_within_budget", int'(done), 1);
      end
      check_val("go_lives_zero", lives_left, 0);
      check_val("go_flag_set", game_over, 1);
      tick(1, 5, "go_restart");
      check_val("go_restart_lives", lives_left, NLIVES);
      check_val("go_restart_flag", game_over, 0);
      check_val("go_restart_x", ball_x, SX);
      check_val("go_restart_act", ball_active, 0);
      tick(0, 5, "go_gap");
      tick(1, 555, "go_serve4");
      check_val("go_serve4_act", ball_active, 1);
      tick(0, 555, "go_move");
      check_val("go_fourth_dx_left", ball_x, SX - 1);
      $display("game_over sequence: lives=%0d x=%0d", lives_left, ball_x);

      // ---------------- held serve ----------------
      apply_reset();
      act_rises = 0;
      prev_act = 0;
      for (int k = 0; k < 2000; k++) begin
         tick(1, avoid_px(), "held_tick");
         if (ball_active && !prev_act) act_rises++;
         prev_act = ball_active;
      end
      check_val("held_serve_count", act_rises, 1);
      check_val("held_lives", lives_left, 2);
      check_val("held_idle", ball_active, 0);
      tick(0, 5, "held_release");
      tick(1, 5, "held_reserve");
      check_val("held_reserve_act", ball_active, 1);
      $display("held serve: activations=%0d lives=%0d", act_rises, lives_left);

      // ---------------- reset mid-flight while hit is high ----------------
      apply_reset();
      tick(1, 555, "rst_serve");
      for (int k = 0; k < 341; k++) tick(0, 555, "rst_play");
      check_val("pre_reset_hit", hit, 1);
      #2 reset = 1'b1;
      #1;
      check_val("async_x", ball_x, SX);
      check_val("async_y", ball_y, SY);
      check_val("async_act", ball_active, 0);
      check_val("async_hit", hit, 0);
      check_val("async_miss", miss, 0);
      check_val("async_lives", lives_left, NLIVES);
      check_val("async_go", game_over, 0);
      @(posedge Ball_Clock);
      #1;
      reset = 1'b0;
      model_reset();
      $display("async reset: x=%0d y=%0d hit=%0b", ball_x, ball_y, hit);

      // ---------------- randomized run ----------------
      px = 300;
      for (int k = 0; k < 15000; k++) begin
         if ($urandom_range(0, 63) == 0) begin
            if ($urandom_range(0, 1) == 0) px = $urandom_range(0, 560);
            else px = (m_x > 70) ? m_x - int'($urandom_range(0, 70)) : 0;
         end
         tick($urandom_range(0, 31) == 0, px, "random");
      end
      $display("random run: %0d ticks, lives=%0d", 15000, lives_left);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
